// File: rtl/btn_conditioner_if.sv
// Button conditioner signal bundle: raw pin in,
// debounced level, edge pulses and press count out.
interface btn_conditioner_if;
    logic       btn_in;
    logic       level;
    logic       press;
    logic       release_pulse;
    logic [7:0] press_cnt;

    modport master (
        output btn_in,
        input  level,
        input  press,
        input  release_pulse,
        input  press_cnt
    );

    modport slave (
        input  btn_in,
        output level,
        output press,
        output release_pulse,
        output press_cnt
    );
endinterface

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, counter-qualified
// debounce FSM, press/release pulses and wrapping press counter.
module btn_conditioner #(
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic rst,
    btn_conditioner_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM_HI = 2'd1,
        HIGH   = 2'd2,
        ARM_LO = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

    logic             s1;
    logic             btn_s;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             press_q;
    logic             rel_q;
    logic [7:0]       pcnt_q;

    // Bring the asynchronous pin into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            s1    <= bus.btn_in;
            btn_s <= s1;
        end
    end

    // Debounce FSM; the counter is cleared on every state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            pcnt_q  <= 8'd0;
        end else begin
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            case (state)
                IDLE: begin
                    level_q <= 1'b0;
                    if (btn_s) begin
                        state <= ARM_HI;
                        cnt   <= '0;
                    end
                end
                ARM_HI: begin
                    level_q <= 1'b0;
                    if (!btn_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state   <= HIGH;
                        cnt     <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                        pcnt_q  <= pcnt_q + 8'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH: begin
                    level_q <= 1'b1;
                    if (!btn_s) begin
                        state <= ARM_LO;
                        cnt   <= '0;
                    end
                end
                ARM_LO: begin
                    level_q <= 1'b1;
                    if (btn_s) begin
                        state <= HIGH;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        level_q <= 1'b0;
                        rel_q   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.level         = level_q;
    assign bus.press         = press_q;
    assign bus.release_pulse = rel_q;
    assign bus.press_cnt     = pcnt_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner (DB_CYCLES=4, CNT_W=3):
// table vectors plus model-driven sequences through a scoreboard queue.
module tb_btn_conditioner;

    localparam int DB = 4;

    typedef struct packed {
        logic       level;
        logic       press;
        logic       rel;
        logic [7:0] cnt;
    } exp_t;

    typedef struct packed {
        logic r;
        logic b;
        exp_t e;
    } vec_t;

    logic clk;
    logic rst;

    btn_conditioner_if bus ();

    btn_conditioner #(
        .DB_CYCLES(DB),
        .CNT_W    (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp;
    int   n_bad;
    int   stepno;
    int   press_seen;
    int   press_at;
    int   rel_seen;
    int   rel_at;
    exp_t sb_q[$];

    // Behavioural reference: a level toggles once the synchronised
    // input has disagreed with it for DB+1 consecutive cycles.
    logic       m_s1;
    logic       m_s2;
    logic       m_lvl;
    int         m_run;
    logic [7:0] m_cnt;
    logic       m_press;
    logic       m_rel;

    task automatic model_edge(input logic r, input logic b);
        m_press = 1'b0;
        m_rel   = 1'b0;
        if (r) begin
            m_s1  = 1'b0;
            m_s2  = 1'b0;
            m_lvl = 1'b0;
            m_run = 0;
            m_cnt = 8'd0;
        end else begin
            if (m_s2 != m_lvl) begin
                m_run++;
                if (m_run == DB + 1) begin
                    m_lvl = m_s2;
                    m_run = 0;
                    if (m_s2) begin
                        m_press = 1'b1;
                        m_cnt   = m_cnt + 8'd1;
                    end else begin
                        m_rel = 1'b1;
                    end
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = b;
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // One clock: drive, push expectation, clock, pop and compare.
    task automatic step(input logic r, input logic b,
                        input logic use_tab, input exp_t te);
        exp_t want;
        exp_t got;
        rst        = r;
        bus.btn_in = b;
        model_edge(r, b);
        if (use_tab) sb_q.push_back(te);
        else sb_q.push_back({m_lvl, m_press, m_rel, m_cnt});
        @(posedge clk);
        #1;
        stepno++;
        got = {bus.level, bus.press, bus.release_pulse, bus.press_cnt};
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard: queue empty at step %0d", stepno);
        end else begin
            want = sb_q.pop_front();
            if (got !== want) begin
                n_bad++;
                $display("FAIL step%0d lvl/prs/rel/cnt: got %b/%b/%b/%0d, required %b/%b/%b/%0d",
                         stepno, got.level, got.press, got.rel, got.cnt,
                         want.level, want.press, want.rel, want.cnt);
            end
        end
        if (bus.press && bus.release_pulse) begin
            n_bad++;
            $display("FAIL exclusive: press and release both 1 at step %0d", stepno);
        end
        if (bus.press) begin
            press_seen++;
            press_at = stepno;
        end
        if (bus.release_pulse) begin
            rel_seen++;
            rel_at = stepno;
        end
    endtask

    task automatic mark();
        stepno     = 0;
        press_seen = 0;
        press_at   = 0;
        rel_seen   = 0;
        rel_at     = 0;
    endtask

    task automatic run(input logic r, input logic b, input int n);
        for (int i = 0; i < n; i++) step(r, b, 1'b0, '0);
    endtask

    vec_t tab[17];
    logic [7:0] last_cnt;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        mark();
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_cnt = 0;
        rst = 1'b1;
        bus.btn_in = 1'b0;

        // Clean press then clean release, expectations written by hand.
        for (int i = 0; i < 6; i++) tab[i] = '{1'b0, 1'b1, '{1'b0, 1'b0, 1'b0, 8'd0}};
        tab[6] = '{1'b0, 1'b1, '{1'b1, 1'b1, 1'b0, 8'd1}};
        tab[7] = '{1'b0, 1'b1, '{1'b1, 1'b0, 1'b0, 8'd1}};
        tab[8] = '{1'b0, 1'b1, '{1'b1, 1'b0, 1'b0, 8'd1}};
        for (int i = 9; i < 15; i++) tab[i] = '{1'b0, 1'b0, '{1'b1, 1'b0, 1'b0, 8'd1}};
        tab[15] = '{1'b0, 1'b0, '{1'b0, 1'b0, 1'b1, 8'd1}};
        tab[16] = '{1'b0, 1'b0, '{1'b0, 1'b0, 1'b0, 8'd1}};

        // Reset, then idle low for 10 cycles.
        run(1'b1, 1'b0, 2);
        run(1'b0, 1'b0, 10);

        mark();
        for (int i = 0; i < 17; i++) step(tab[i].r, tab[i].b, 1'b1, tab[i].e);
        check("clean_press_count", press_seen, 1);
        check("clean_press_edge", press_at, 7);
        check("clean_release_edge", rel_at, 16);

        // Bounce on press.
        mark();
        step(0, 1, 0, '0); step(0, 0, 0, '0); step(0, 1, 0, '0);
        step(0, 1, 0, '0); step(0, 0, 0, '0); step(0, 1, 0, '0);
        run(1'b0, 1'b1, 10);
        check("bounce_press_count", press_seen, 1);
        check("bounce_press_edge", press_at, 12);
        check("bounce_press_cnt", bus.press_cnt, 2);

        // Release with bounce.
        mark();
        step(0, 0, 0, '0); step(0, 1, 0, '0); step(0, 0, 0, '0);
        run(1'b0, 1'b0, 10);
        check("bounce_rel_count", rel_seen, 1);
        check("bounce_rel_edge", rel_at, 9);
        check("bounce_rel_press", press_seen, 0);

        // Wrap of press_cnt from a fresh reset.
        run(1'b1, 1'b0, 1);
        mark();
        last_cnt = 8'hff;
        for (int k = 0; k < 256; k++) begin
            run(1'b0, 1'b1, 8);
            last_cnt = bus.press_cnt;
            run(1'b0, 1'b0, 8);
        end
        check("wrap_presses", press_seen, 256);
        check("wrap_cnt_zero", last_cnt, 0);

        // Reset mid-press (ARM_HI, cnt=2).
        run(1'b1, 1'b0, 1);
        run(1'b0, 1'b1, 5);
        step(1, 1, 0, '0);
        check("midrst_level", bus.level, 0);
        mark();
        run(1'b0, 1'b1, 10);
        check("midrst_press_count", press_seen, 1);
        check("midrst_press_edge", press_at, 7);
        check("midrst_cnt", bus.press_cnt, 1);

        // Reset on the would-be press edge.
        run(1'b1, 1'b0, 1);
        run(1'b0, 1'b1, 6);
        mark();
        step(1, 1, 0, '0);
        check("rstwin_press", press_seen, 0);
        check("rstwin_cnt", bus.press_cnt, 0);
        mark();
        run(1'b0, 1'b1, 10);
        check("rstwin_after_edge", press_at, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
